nav_arbiter: RTL and testbench

//  Shares the single navigate unit between two requesters: cmd_proc (manual, prefix m_) and maze_solve (solver, prefix s_).

---
 rtl/nav_arbiter_if.sv | 40 ++++
 rtl/nav_arbiter.sv | 117 +++++++++++
 tb/tb_nav_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nav_arbiter_if.sv
// rtl/nav_arbiter_if.sv - requester and navigate signal bundle for nav_arbiter
// Slave side is the arbiter; master side is whoever drives requests and navigate's completion.
interface nav_arbiter_if;
  logic        m_strt_hdng;
  logic        m_strt_mv;
  logic [11:0] m_dsrd_hdng;
  logic        m_stp_lft;
  logic        m_stp_rght;
  logic        m_mv_cmplt;

  logic        s_strt_hdng;
  logic        s_strt_mv;
  logic [11:0] s_dsrd_hdng;
  logic        s_stp_lft;
  logic        s_stp_rght;
  logic        s_mv_cmplt;

  logic        n_strt_hdng;
  logic        n_strt_mv;
  logic [11:0] n_dsrd_hdng;
  logic        n_stp_lft;
  logic        n_stp_rght;
  logic        n_mv_cmplt;

  modport slave (
    input  m_strt_hdng, m_strt_mv, m_dsrd_hdng, m_stp_lft, m_stp_rght,
    input  s_strt_hdng, s_strt_mv, s_dsrd_hdng, s_stp_lft, s_stp_rght,
    input  n_mv_cmplt,
    output m_mv_cmplt, s_mv_cmplt,
    output n_strt_hdng, n_strt_mv, n_dsrd_hdng, n_stp_lft, n_stp_rght
  );

  modport master (
    output m_strt_hdng, m_strt_mv, m_dsrd_hdng, m_stp_lft, m_stp_rght,
    output s_strt_hdng, s_strt_mv, s_dsrd_hdng, s_stp_lft, s_stp_rght,
    output n_mv_cmplt,
    input  m_mv_cmplt, s_mv_cmplt,
    input  n_strt_hdng, n_strt_mv, n_dsrd_hdng, n_stp_lft, n_stp_rght
  );
endinterface

// File: rtl/nav_arbiter.sv
// rtl/nav_arbiter.sv - two-requester arbiter in front of the single navigate unit
// One request slot per requester, fixed priority chosen by cmd_md, watchdog on the navigate wait.
module nav_arbiter #(
  parameter int TMO_CYCLES = 5_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_md,
  nav_arbiter_if.slave bus,
  output logic         busy,
  output logic         grant_src,
  output logic         req_drop,
  output logic         tmo_err
);
  localparam int              WD_W    = $clog2(TMO_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  // Index 0 is the manual requester, index 1 the solver.
  logic [1:0]       strt_hdng, strt_mv, strt_any, stp_lft_in, stp_rght_in;
  logic [1:0][11:0] hdng_in;
  logic [1:0]       slot_vld, slot_mv, slot_lft, slot_rght;
  logic [1:0][11:0] slot_hdng;
  logic [1:0]       free_vec, occupied, load, drop;
  logic [WD_W-1:0]  wd;
  logic             grant, pick, owner_mv, timeout, release_slot;

  assign strt_hdng   = {bus.s_strt_hdng, bus.m_strt_hdng};
  assign strt_mv     = {bus.s_strt_mv,   bus.m_strt_mv};
  assign stp_lft_in  = {bus.s_stp_lft,   bus.m_stp_lft};
  assign stp_rght_in = {bus.s_stp_rght,  bus.m_stp_rght};
  assign hdng_in     = {bus.s_dsrd_hdng, bus.m_dsrd_hdng};
  assign strt_any    = strt_hdng | strt_mv;

  assign owner_mv     = slot_mv[grant_src];
  assign timeout      = (state == WAIT) && !bus.n_mv_cmplt && (wd == WD_LAST);
  assign release_slot = (state == DONE) || timeout;
  assign grant        = (state == IDLE) && (|slot_vld);
  assign pick         = (&slot_vld) ? !cmd_md : slot_vld[1];

  // A slot being released this cycle counts as empty so the owner can queue its next request.
  assign free_vec = release_slot ? (grant_src ? 2'b10 : 2'b01) : 2'b00;
  assign occupied = slot_vld & ~free_vec;
  assign load     = strt_any & ~occupied;
  assign drop     = strt_any & (occupied | (strt_hdng & strt_mv));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (bus.n_mv_cmplt)  state_nxt = DONE;
        else if (timeout)    state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wd              <= '0;
      grant_src       <= 1'b0;
      bus.n_dsrd_hdng <= 12'h000;
      bus.n_stp_lft   <= 1'b0;
      bus.n_stp_rght  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        wd        <= '0;
        grant_src <= pick;
        if (slot_mv[pick]) begin
          bus.n_stp_lft  <= slot_lft[pick];
          bus.n_stp_rght <= slot_rght[pick];
        end else begin
          bus.n_dsrd_hdng <= slot_hdng[pick];
        end
      end else if (state == WAIT) begin
        wd <= wd + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld  <= '0;
      slot_mv   <= '0;
      slot_lft  <= '0;
      slot_rght <= '0;
      slot_hdng <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (load[r]) begin
          slot_vld[r]  <= 1'b1;
          slot_mv[r]   <= !strt_hdng[r];
          slot_hdng[r] <= hdng_in[r];
          slot_lft[r]  <= stp_lft_in[r];
          slot_rght[r] <= stp_rght_in[r];
        end else if (free_vec[r]) begin
          slot_vld[r] <= 1'b0;
        end
      end
    end
  end

  assign bus.n_strt_hdng = (state == ISSUE) && !owner_mv;
  assign bus.n_strt_mv   = (state == ISSUE) &&  owner_mv;
  assign bus.m_mv_cmplt  = (state == DONE)  && !grant_src;
  assign bus.s_mv_cmplt  = (state == DONE)  &&  grant_src;
  assign busy            = (state != IDLE);
  assign req_drop        = |drop;
  assign tmo_err         = timeout;
endmodule

// File: tb/tb_nav_arbiter.sv
// tb/tb_nav_arbiter.sv - self-checking bench for nav_arbiter
// A grant-age model is checked every cycle; directed scenarios add literal expectations.
module tb_nav_arbiter;
  localparam int TMO = 16;

  logic clk, rst_n, cmd_md;
  logic busy, grant_src, req_drop, tmo_err;
  int   n_run, n_fail;

  nav_arbiter_if bus();

  nav_arbiter #(.TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .bus(bus),
    .busy(busy), .grant_src(grant_src), .req_drop(req_drop), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pending requests per requester, current owner and its age in cycles since the grant.
  logic        pv[2], pmv[2], pl[2], pr[2];
  logic [11:0] phd[2];
  logic        ih[2], im[2], il[2], ir[2], occ[2];
  logic [11:0] hin[2];
  int          own, age, pick;
  logic        dn, gs, nl, nr, e_mv, e_tmo, e_drop, freeing;
  logic [11:0] nh;

  always @(negedge clk) begin
    if (!rst_n) begin
      own = -1; age = 0; dn = 1'b0; gs = 1'b0; nh = 12'h000; nl = 1'b0; nr = 1'b0;
      for (int r = 0; r < 2; r++) begin
        pv[r] = 1'b0; pmv[r] = 1'b0; pl[r] = 1'b0; pr[r] = 1'b0; phd[r] = 12'h000;
      end
      chk("rst_busy", busy, 0);
      chk("rst_grant_src", grant_src, 0);
      chk("rst_n_dsrd_hdng", bus.n_dsrd_hdng, 0);
      chk("rst_n_stp", {bus.n_stp_lft, bus.n_stp_rght}, 0);
      chk("rst_pulses", {bus.n_strt_hdng, bus.n_strt_mv, bus.m_mv_cmplt, bus.s_mv_cmplt, tmo_err}, 0);
    end else begin
      ih[0] = bus.m_strt_hdng; im[0] = bus.m_strt_mv; hin[0] = bus.m_dsrd_hdng;
      il[0] = bus.m_stp_lft;   ir[0] = bus.m_stp_rght;
      ih[1] = bus.s_strt_hdng; im[1] = bus.s_strt_mv; hin[1] = bus.s_dsrd_hdng;
      il[1] = bus.s_stp_lft;   ir[1] = bus.s_stp_rght;
      e_mv  = (own >= 0) ? pmv[own] : 1'b0;
      e_tmo = (own >= 0) && !dn && (age == TMO + 1) && !bus.n_mv_cmplt;
      e_drop = 1'b0;
      for (int r = 0; r < 2; r++) begin
        freeing = (own == r) && (dn || e_tmo);
        occ[r]  = pv[r] && !freeing;
        if ((ih[r] || im[r]) && (occ[r] || (ih[r] && im[r]))) e_drop = 1'b1;
      end
      chk("busy", busy, (own >= 0) && (age >= 1));
      chk("grant_src", grant_src, gs);
      chk("n_dsrd_hdng", bus.n_dsrd_hdng, nh);
      chk("n_stp_lft", bus.n_stp_lft, nl);
      chk("n_stp_rght", bus.n_stp_rght, nr);
      chk("n_strt_hdng", bus.n_strt_hdng, (own >= 0) && (age == 1) && !e_mv);
      chk("n_strt_mv", bus.n_strt_mv, (own >= 0) && (age == 1) && e_mv);
      chk("m_mv_cmplt", bus.m_mv_cmplt, dn && !gs);
      chk("s_mv_cmplt", bus.s_mv_cmplt, dn && gs);
      chk("req_drop", req_drop, e_drop);
      chk("tmo_err", tmo_err, e_tmo);
      // advance to the next cycle
      if (own < 0) begin
        if (pv[0] || pv[1]) begin
          pick = (pv[0] && pv[1]) ? (cmd_md ? 0 : 1) : (pv[1] ? 1 : 0);
          own = pick; age = 1; gs = (pick == 1);
          if (pmv[pick]) begin nl = pl[pick]; nr = pr[pick]; end
          else nh = phd[pick];
        end
      end else if (dn || e_tmo) begin
        pv[own] = 1'b0; own = -1; dn = 1'b0;
      end else begin
        if (age >= 2 && bus.n_mv_cmplt) dn = 1'b1;
        age++;
      end
      for (int r = 0; r < 2; r++) begin
        if ((ih[r] || im[r]) && !occ[r]) begin
          pv[r] = 1'b1; pmv[r] = !ih[r]; phd[r] = hin[r]; pl[r] = il[r]; pr[r] = ir[r];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0; cmd_md = 1'b0;
    bus.m_strt_hdng = 0; bus.m_strt_mv = 0; bus.m_dsrd_hdng = 0; bus.m_stp_lft = 0; bus.m_stp_rght = 0;
    bus.s_strt_hdng = 0; bus.s_strt_mv = 0; bus.s_dsrd_hdng = 0; bus.s_stp_lft = 0; bus.s_stp_rght = 0;
    bus.n_mv_cmplt = 0;
    tick(3); rst_n = 1'b1; tick(2);

    // solo manual heading
    bus.m_strt_hdng = 1; bus.m_dsrd_hdng = 12'h3FF;
    tick(1); bus.m_strt_hdng = 0;
    tick(1); @(negedge clk);
    chk("t1_strt_hdng", bus.n_strt_hdng, 1); chk("t1_hdng", bus.n_dsrd_hdng, 12'h3FF);
    tick(8); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0; @(negedge clk);
    chk("t1_m_cmplt", bus.m_mv_cmplt, 1); chk("t1_s_cmplt", bus.s_mv_cmplt, 0);
    tick(1); @(negedge clk); chk("t1_idle", busy, 0);
    tick(2);

    // contention, manual priority
    cmd_md = 1;
    bus.m_strt_mv = 1; bus.m_stp_lft = 0; bus.m_stp_rght = 1;
    bus.s_strt_hdng = 1; bus.s_dsrd_hdng = 12'h7FF;
    tick(1); bus.m_strt_mv = 0; bus.s_strt_hdng = 0; bus.m_stp_rght = 0;
    tick(1); @(negedge clk);
    chk("t3_strt_mv", bus.n_strt_mv, 1); chk("t3_src", grant_src, 0);
    chk("t3_rght", bus.n_stp_rght, 1); chk("t3_hdng_held", bus.n_dsrd_hdng, 12'h3FF);
    tick(2); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0;
    tick(2); @(negedge clk);
    chk("t3_s_strt", bus.n_strt_hdng, 1); chk("t3_s_hdng", bus.n_dsrd_hdng, 12'h7FF); chk("t3_s_src", grant_src, 1);
    tick(2); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0;
    tick(3);

    // contention, solver priority
    cmd_md = 0;
    bus.m_strt_mv = 1; bus.m_stp_lft = 1; bus.m_stp_rght = 0;
    bus.s_strt_hdng = 1; bus.s_dsrd_hdng = 12'h5A5;
    tick(1); bus.m_strt_mv = 0; bus.s_strt_hdng = 0; bus.m_stp_lft = 0;
    tick(1); @(negedge clk);
    chk("t2_strt_hdng", bus.n_strt_hdng, 1); chk("t2_src", grant_src, 1); chk("t2_hdng", bus.n_dsrd_hdng, 12'h5A5);
    tick(1); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0; @(negedge clk); chk("t2_s_cmplt", bus.s_mv_cmplt, 1);
    tick(2); @(negedge clk);
    chk("t2_strt_mv", bus.n_strt_mv, 1); chk("t2_lft", bus.n_stp_lft, 1);
    chk("t2_rght", bus.n_stp_rght, 0); chk("t2_m_src", grant_src, 0);
    tick(1); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0;
    tick(3);

    // drops: solver re-request while granted, then manual dual pulse
    bus.s_strt_hdng = 1; bus.s_dsrd_hdng = 12'h0AA;
    tick(1); bus.s_strt_hdng = 0;
    tick(3); bus.s_strt_hdng = 1; bus.s_dsrd_hdng = 12'h111; @(negedge clk);
    chk("t4_drop", req_drop, 1);
    tick(1); bus.s_strt_hdng = 0; @(negedge clk); chk("t4_drop_end", req_drop, 0);
    tick(1); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0;
    tick(3); @(negedge clk); chk("t4_no_reissue", {busy, bus.n_strt_hdng}, 0);
    tick(1);
    bus.m_strt_hdng = 1; bus.m_strt_mv = 1; bus.m_dsrd_hdng = 12'h222; bus.m_stp_lft = 1; bus.m_stp_rght = 1;
    @(negedge clk); chk("t4_dual_drop", req_drop, 1);
    tick(1); bus.m_strt_hdng = 0; bus.m_strt_mv = 0; bus.m_stp_lft = 0; bus.m_stp_rght = 0;
    tick(1); @(negedge clk);
    chk("t4_dual_hdng", {bus.n_strt_hdng, bus.n_strt_mv}, 2'b10); chk("t4_dual_val", bus.n_dsrd_hdng, 12'h222);
    tick(2); bus.m_strt_mv = 1; bus.s_strt_hdng = 1; bus.s_strt_mv = 1; bus.s_dsrd_hdng = 12'h333;
    @(negedge clk); chk("t4_both_drop", req_drop, 1);
    tick(1); bus.m_strt_mv = 0; bus.s_strt_hdng = 0; bus.s_strt_mv = 0; bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0; @(negedge clk); chk("t4_m_cmplt", bus.m_mv_cmplt, 1);
    tick(2); @(negedge clk);
    chk("t4_s_strt", bus.n_strt_hdng, 1); chk("t4_s_hdng", bus.n_dsrd_hdng, 12'h333);
    tick(1); bus.n_mv_cmplt = 1;
    tick(1); bus.n_mv_cmplt = 0;
    tick(3);

    // watchdog abort, stale completion during ISSUE
    bus.s_strt_hdng = 1; bus.s_dsrd_hdng = 12'h0F0;
    tick(1); bus.s_strt_hdng = 0;
    tick(1); bus.n_mv_cmplt = 1; @(negedge clk); chk("t5_issue", bus.n_strt_hdng, 1);
    tick(1); bus.n_mv_cmplt = 0;
    tick(14); @(negedge clk); chk("t5_tmo_early", tmo_err, 0);
    tick(1); @(negedge clk); chk("t5_tmo", tmo_err, 1); chk("t5_no_cmplt", bus.s_mv_cmplt, 0);
    tick(1); @(negedge clk); chk("t5_idle", busy, 0); chk("t5_no_cmplt2", bus.s_mv_cmplt, 0);
    tick(2);

    // completion on the timeout cycle wins
    bus.m_strt_hdng = 1; bus.m_dsrd_hdng = 12'h00F;
    tick(1); bus.m_strt_hdng = 0;
    tick(17); bus.n_mv_cmplt = 1; @(negedge clk); chk("t5b_no_tmo", tmo_err, 0);
    tick(1); bus.n_mv_cmplt = 0; @(negedge clk); chk("t5b_cmplt", bus.m_mv_cmplt, 1);
    tick(3);

    // asynchronous reset mid-WAIT
    bus.m_strt_hdng = 1; bus.m_dsrd_hdng = 12'hABC;
    tick(1); bus.m_strt_hdng = 0;
    tick(4); @(negedge clk); chk("t6_waiting", busy, 1);
    tick(1); rst_n = 1'b0; #1;
    chk("t6_async_busy", busy, 0); chk("t6_async_hdng", bus.n_dsrd_hdng, 12'h000); chk("t6_async_src", grant_src, 0);
    tick(2); rst_n = 1'b1;
    tick(15); @(negedge clk); chk("t6_quiet", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
